// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of request, data, grant and output handshake signals for mux8_rr_arbiter.
// The master side drives requests, data and ready; the slave side is the arbiter.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] din;
  logic       dout_ready;
  logic       dout;
  logic       dout_valid;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  modport master (
    output req, din, dout_ready,
    input  dout, dout_valid, gnt, sel, busy
  );

  modport slave (
    input  req, din, dout_ready,
    output dout, dout_valid, gnt, sel, busy
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter that muxes one data bit from the granted requester,
// holding each grant for up to MAX_BURST beats with a one-cycle bubble between grants.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux8_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] last_q, last_d;
  logic [2:0] pick;
  logic       found;
  logic       valid;

  // Scan last+1 .. last+8 (mod 8) so the just-released requester is checked last.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (!found && bus.req[last_q + 3'(i)]) begin
        pick  = last_q + 3'(i);
        found = 1'b1;
      end
    end
  end

  assign valid = (state_q == GRANT) && bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          sel_d   = pick;
          gnt_d   = 8'd1 << pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A transfer needs req[sel], so a dropped request releases without counting a beat.
        if (!valid || (bus.dout_ready && cnt_q == LAST_BEAT)) begin
          last_d  = sel_q;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.dout_ready) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.dout       = bus.din[sel_q];
  assign bus.dout_valid = valid;
  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a MAX_BURST=4 instance and a MAX_BURST=1 instance,
// each step checked against hand-computed grant order, burst lengths and bubbles.
module tb_mux8_rr_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] dv;
  logic [7:0] dv1;

  mux8_rr_arbiter_if bus0 ();
  mux8_rr_arbiter_if bus1 ();

  mux8_rr_arbiter #(.MAX_BURST(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mux8_rr_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later; gnt must be at most one-hot on both instances.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($countones(bus0.gnt) <= 1), 32'd1);
    chk("onehot1", 32'($countones(bus1.gnt) <= 1), 32'd1);
  endtask

  task automatic chk_grant0(input string tag, input int unsigned idx);
    chk({tag, "_gnt"},   32'(bus0.gnt), 32'(8'd1 << idx));
    chk({tag, "_sel"},   32'(bus0.sel), idx);
    chk({tag, "_busy"},  32'(bus0.busy), 32'd1);
    chk({tag, "_valid"}, 32'(bus0.dout_valid), 32'd1);
    chk({tag, "_dout"},  32'(bus0.dout), 32'(dv[idx]));
  endtask

  task automatic chk_idle0(input string tag);
    chk({tag, "_gnt"},   32'(bus0.gnt), 32'd0);
    chk({tag, "_busy"},  32'(bus0.busy), 32'd0);
    chk({tag, "_valid"}, 32'(bus0.dout_valid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    dv    = 8'h01;
    dv1   = 8'hB2;
    rst_n = 1'b0;
    bus0.req = '0; bus0.din = dv;  bus0.dout_ready = 1'b1;
    bus1.req = '0; bus1.din = dv1; bus1.dout_ready = 1'b1;
    #12;
    chk_idle0("rst");
    chk("rst_sel", 32'(bus0.sel), 32'd0);
    chk("rst_dout", 32'(bus0.dout), 32'd1);
    @(posedge clk); #1;
    chk_idle0("rst_hold");
    rst_n = 1'b1;

    // 0 and 7 alternate, 4 beats each, one bubble between
    dv = 8'h80; bus0.din = dv;
    bus0.req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        chk_grant0("alt", (g % 2 == 0) ? 0 : 7);
      end
      step();
      chk_idle0("alt_bubble");
    end

    // stall on requester 3, then 4 transfers and release
    bus0.req = 8'h08;
    bus0.dout_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk_grant0("stall", 3);
    end
    bus0.dout_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step();
      chk_grant0("post_stall", 3);
    end
    step();
    chk_idle0("stall_rel");

    // requester 2 drops after 2 beats; 0 wins next with 2 also pending
    bus0.req = 8'h04;
    step(); chk_grant0("drop", 2);
    step(); chk_grant0("drop", 2);
    step(); chk_grant0("drop", 2);
    bus0.req = 8'h01;
    step(); chk_idle0("drop_rel");
    bus0.req = 8'h05;
    step(); chk_grant0("after_drop", 0);
    bus0.req = 8'h00;
    step(); chk_idle0("rel0");
    step(); chk_idle0("idle_hold");
    chk("idle_sel_holds", 32'(bus0.sel), 32'd0);

    // MAX_BURST=1 instance walks 0..7,0 with a bubble after each beat
    bus1.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("mb1_sel",  32'(bus1.sel), 32'(k % 8));
      chk("mb1_gnt",  32'(bus1.gnt), 32'(8'd1 << (k % 8)));
      chk("mb1_dout", 32'(bus1.dout), 32'(dv1[k % 8]));
      step();
      chk("mb1_bubble", 32'(bus1.busy), 32'd0);
    end
    bus1.req = 8'h00;

    // asynchronous reset mid-burst on requester 5
    bus0.req = 8'h20;
    bus0.dout_ready = 1'b0;
    step(); chk_grant0("pre_rst", 5);
    step(); chk_grant0("pre_rst", 5);
    #2 rst_n = 1'b0;
    #1;
    chk_idle0("async_rst");
    chk("async_rst_sel", 32'(bus0.sel), 32'd0);
    chk("async_rst_dout", 32'(bus0.dout), 32'(dv[0]));
    #1 rst_n = 1'b1;
    bus0.req = 8'hFF;
    bus0.dout_ready = 1'b1;
    step(); chk_grant0("after_rst", 0);

    // lone requester 6 re-granted repeatedly
    bus0.req = 8'h40;
    step(); chk_idle0("to_six");
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        chk_grant0("lone6", 6);
      end
      step();
      chk_idle0("lone6_bubble");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
